// File: rtl/datapath.sv
// 32-bit register-file datapath: shared bus, register bank, 64-bit-result ALU and Z.
// Optional signed divider is enabled by defining DATAPATH_DIV_EN.
module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
  input  logic        IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL,
  input  logic        NEG, NOT, MUL, DIV,
  input  logic        Read,
  input  logic [31:0] Mdatain,
  output logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7,
  output logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15,
  output logic [31:0] HI, LO, PC_out, IR, MAR, Y,
  output logic [63:0] Z,
  output logic [31:0] BusMuxOut_signal
);

  logic [15:0] rin, rout;
  logic [31:0] rf [16];
  logic [31:0] hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q;
  logic [63:0] z_q;
  logic [31:0] bus;
  logic [63:0] alu_res;

  assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                 R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  // Assignments run from lowest to highest priority so the last match wins.
  always_comb begin
    bus = '0;
    if (Cout)      bus = {{13{ir_q[18]}}, ir_q[18:0]};
    if (InPortout) bus = '0;
    if (MDRout)    bus = mdr_q;
    if (PCout)     bus = pc_q;
    if (Zlowout)   bus = z_q[31:0];
    if (Zhighout)  bus = z_q[63:32];
    if (LOout)     bus = lo_q;
    if (HIout)     bus = hi_q;
    for (int i = 15; i >= 0; i--)
      if (rout[i]) bus = rf[i];
  end

  logic [4:0]         sh;
  logic [63:0]        yy, rot_r, rot_l;
  logic [31:0]        sra;
  logic signed [63:0] prod;

  assign sh    = bus[4:0];
  assign yy    = {y_q, y_q};
  assign rot_r = yy >> sh;
  assign rot_l = yy << sh;
  assign sra   = $signed(y_q) >>> sh;
  assign prod  = $signed(y_q) * $signed(bus);

`ifdef DATAPATH_DIV_EN
  logic signed [31:0] quo, rem;
  assign quo = (bus == '0) ? '0 : $signed(y_q) / $signed(bus);
  assign rem = (bus == '0) ? '0 : $signed(y_q) % $signed(bus);
`endif

  always_comb begin
    alu_res = '0;
    if      (IncPC) alu_res = {32'd0, bus + 32'd1};
    else if (ADD)   alu_res = {32'd0, y_q + bus};
    else if (SUB)   alu_res = {32'd0, y_q - bus};
    else if (AND)   alu_res = {32'd0, y_q & bus};
    else if (OR)    alu_res = {32'd0, y_q | bus};
    else if (SHR)   alu_res = {32'd0, y_q >> sh};
    else if (SHRA)  alu_res = {32'd0, sra};
    else if (SHL)   alu_res = {32'd0, y_q << sh};
    else if (ROR)   alu_res = {32'd0, rot_r[31:0]};
    else if (ROL)   alu_res = {32'd0, rot_l[63:32]};
    else if (NEG)   alu_res = {32'd0, 32'd0 - bus};
    else if (NOT)   alu_res = {32'd0, ~bus};
    else if (MUL)   alu_res = prod;
`ifdef DATAPATH_DIV_EN
    else if (DIV)   alu_res = {rem, quo};
`else
    else if (DIV)   alu_res = '0;
`endif
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      y_q   <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (rin[i]) rf[i] <= bus;
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (PCin)  pc_q  <= bus;
      if (IRin)  ir_q  <= bus;
      if (Yin)   y_q   <= bus;
      if (MARin) mar_q <= bus;
      if (MDRin) mdr_q <= Read ? Mdatain : bus;
      if (Zin)   z_q   <= alu_res;
    end
  end

  assign R0  = rf[0];  assign R1  = rf[1];  assign R2  = rf[2];  assign R3  = rf[3];
  assign R4  = rf[4];  assign R5  = rf[5];  assign R6  = rf[6];  assign R7  = rf[7];
  assign R8  = rf[8];  assign R9  = rf[9];  assign R10 = rf[10]; assign R11 = rf[11];
  assign R12 = rf[12]; assign R13 = rf[13]; assign R14 = rf[14]; assign R15 = rf[15];
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign PC_out = pc_q;
  assign IR     = ir_q;
  assign MAR    = mar_q;
  assign Y      = y_q;
  assign Z      = z_q;
  assign BusMuxOut_signal = bus;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: ALU vector table, hand sequences, randomized ops vs. model.
module tb_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] rin, rout;
  logic        HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout;
  logic [13:0] alu;
  logic        Read;
  logic [31:0] Mdatain;
  logic [31:0] rq [16];
  logic [31:0] HI, LO, PC_out, IR, MAR, Y, bus;
  logic [63:0] Z;

  int pass = 0, total = 0;

  always #5 clock = ~clock;

  datapath dut (
    .clock(clock), .clear(clear),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .MARin(MARin), .MDRin(MDRin),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout),
    .IncPC(alu[0]), .ADD(alu[1]), .SUB(alu[2]), .AND(alu[3]), .OR(alu[4]),
    .SHR(alu[5]), .SHRA(alu[6]), .SHL(alu[7]), .ROR(alu[8]), .ROL(alu[9]),
    .NEG(alu[10]), .NOT(alu[11]), .MUL(alu[12]), .DIV(alu[13]),
    .Read(Read), .Mdatain(Mdatain),
    .R0(rq[0]), .R1(rq[1]), .R2(rq[2]), .R3(rq[3]), .R4(rq[4]), .R5(rq[5]),
    .R6(rq[6]), .R7(rq[7]), .R8(rq[8]), .R9(rq[9]), .R10(rq[10]), .R11(rq[11]),
    .R12(rq[12]), .R13(rq[13]), .R14(rq[14]), .R15(rq[15]),
    .HI(HI), .LO(LO), .PC_out(PC_out), .IR(IR), .MAR(MAR), .Y(Y),
    .Z(Z), .BusMuxOut_signal(bus)
  );

  typedef struct {
    int          op;
    logic [31:0] y;
    logic [31:0] b;
    logic [63:0] z;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle();
    rin = '0; rout = '0; alu = '0; Read = 1'b0; Mdatain = '0;
    {HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin} = '0;
    {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout} = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
  endtask

  task automatic alu_op(input int op, input logic [31:0] y, input logic [31:0] b);
    load_mdr(y);
    MDRout = 1'b1; Yin = 1'b1; tick();
    load_mdr(b);
    MDRout = 1'b1; alu[op] = 1'b1; Zin = 1'b1; tick();
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 16; i++) check($sformatf("%s_R%0d", tag, i), {32'd0, rq[i]}, 64'd0);
    check({tag, "_HI"}, {32'd0, HI}, 64'd0);
    check({tag, "_LO"}, {32'd0, LO}, 64'd0);
    check({tag, "_PC"}, {32'd0, PC_out}, 64'd0);
    check({tag, "_IR"}, {32'd0, IR}, 64'd0);
    check({tag, "_MAR"}, {32'd0, MAR}, 64'd0);
    check({tag, "_Y"}, {32'd0, Y}, 64'd0);
    check({tag, "_Z"}, Z, 64'd0);
  endtask

  // Reference ALU computed from the arithmetic definitions of each operation.
  function automatic logic [63:0] ref_alu(input int op, input logic [31:0] y, input logic [31:0] b);
    logic [31:0] t, ay, ab, q, r;
    longint      sa, sb;
    int          n;
    n = int'(b[4:0]);
    t = y;
    case (op)
      0:  return {32'd0, b + 32'd1};
      1:  return {32'd0, y + b};
      2:  return {32'd0, y - b};
      3:  return {32'd0, y & b};
      4:  return {32'd0, y | b};
      5:  return {32'd0, y >> n};
      6:  begin
            for (int k = 0; k < n; k++) t = {t[31], t[31:1]};
            return {32'd0, t};
          end
      7:  return {32'd0, y << n};
      8:  begin
            for (int k = 0; k < n; k++) t = {t[0], t[31:1]};
            return {32'd0, t};
          end
      9:  begin
            for (int k = 0; k < n; k++) t = {t[30:0], t[31]};
            return {32'd0, t};
          end
      10: return {32'd0, -b};
      11: return {32'd0, ~b};
      12: begin
            sa = longint'(int'(y)); sb = longint'(int'(b));
            return sa * sb;
          end
      13: begin
`ifdef DATAPATH_DIV_EN
            if (b == 0) return 64'd0;
            ay = y[31] ? -y : y;
            ab = b[31] ? -b : b;
            q = ay / ab; r = ay % ab;
            if (y[31] ^ b[31]) q = -q;
            if (y[31]) r = -r;
            return {r, q};
`else
            ay = '0; ab = '0; q = '0; r = '0;
            return 64'd0;
`endif
          end
      default: return 64'd0;
    endcase
  endfunction

  initial begin
    tbl[0]  = '{0,  32'h0,        32'hFFFFFFFF, 64'h0};
    tbl[1]  = '{1,  32'hFFFFFFFF, 32'h2,        64'h1};
    tbl[2]  = '{2,  32'h5,        32'h7,        64'hFFFFFFFE};
    tbl[3]  = '{3,  32'h67,       32'h10,       64'h0};
    tbl[4]  = '{4,  32'hF0,       32'h0F,       64'hFF};
    tbl[5]  = '{5,  32'h80000000, 32'h24,       64'h08000000};
    tbl[6]  = '{6,  32'h80000000, 32'h4,        64'hF8000000};
    tbl[7]  = '{7,  32'h1,        32'd31,       64'h80000000};
    tbl[8]  = '{8,  32'h1,        32'h1,        64'h80000000};
    tbl[9]  = '{9,  32'h80000001, 32'h1,        64'h3};
    tbl[10] = '{10, 32'h123,      32'h1,        64'hFFFFFFFF};
    tbl[11] = '{11, 32'h0,        32'h0F0F0F0F, 64'hF0F0F0F0};
    tbl[12] = '{12, 32'hFFFFFFFE, 32'h3,        64'hFFFFFFFF_FFFFFFFA};
`ifdef DATAPATH_DIV_EN
    tbl[13] = '{13, 32'd17,       32'd5,        64'h00000002_00000003};
    tbl[14] = '{13, 32'hFFFFFFEF, 32'd5,        64'hFFFFFFFE_FFFFFFFD};
`else
    tbl[13] = '{13, 32'd17,       32'd5,        64'h0};
    tbl[14] = '{13, 32'hFFFFFFEF, 32'd5,        64'h0};
`endif
    tbl[15] = '{13, 32'd9,        32'd0,        64'h0};
    tbl[16] = '{8,  32'h12345678, 32'h0,        64'h12345678};

    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_all_zero("reset");

    // R1=5, R3=0x10, multiply into Z, split into LO/HI
    load_mdr(32'h5);  MDRout = 1; rin[1] = 1; tick();
    load_mdr(32'h10); MDRout = 1; rin[3] = 1; tick();
    rout[3] = 1; Yin = 1; tick();
    rout[1] = 1; alu[12] = 1; Zin = 1; tick();
    Zlowout = 1; LOin = 1; tick();
    Zhighout = 1; HIin = 1; tick();
    check("mul_LO", {32'd0, LO}, 64'h50);
    check("mul_HI", {32'd0, HI}, 64'h0);

    // Instruction fetch from PC=0
    PCout = 1; MARin = 1; alu[0] = 1; Zin = 1; tick();
    Zlowout = 1; PCin = 1; tick();
    check("fetch_MAR", {32'd0, MAR}, 64'h0);
    check("fetch_PC", {32'd0, PC_out}, 64'h1);
    load_mdr(32'h112B0000);
    MDRout = 1; IRin = 1; tick();
    check("fetch_IR", {32'd0, IR}, 64'h112B0000);

    // Bus: Cout sign extension, priority, and idle bus
    load_mdr(32'hABC40001); MDRout = 1; IRin = 1; tick();
    Cout = 1; #1;
    check("bus_cout", {32'd0, bus}, 64'hFFFC0001);
    rout[1] = 1; rout[3] = 1; PCout = 1; #1;
    check("bus_prio_r1", {32'd0, bus}, 64'h5);
    idle(); HIout = 1; LOout = 1; InPortout = 1; #1;
    check("bus_prio_hi", {32'd0, bus}, 64'h0);
    idle(); LOout = 1; InPortout = 1; #1;
    check("bus_prio_lo", {32'd0, bus}, 64'h50);
    idle(); #1;
    check("bus_idle", {32'd0, bus}, 64'h0);
    tick();

    for (int i = 0; i < 17; i++) begin
      alu_op(tbl[i].op, tbl[i].y, tbl[i].b);
      check($sformatf("tbl%0d_op%0d", i, tbl[i].op), Z, tbl[i].z);
    end

    // No operation selected -> result 0
    alu_op(1, 32'h7, 32'h8);
    load_mdr(32'h9); MDRout = 1; Zin = 1; tick();
    check("no_op", Z, 64'h0);

    // ALU uses old Y while Y is loaded in the same cycle
    load_mdr(32'd100); MDRout = 1; Yin = 1; tick();
    load_mdr(32'd7);   MDRout = 1; Yin = 1; alu[1] = 1; Zin = 1; tick();
    check("rw_same_Z", Z, 64'd107);
    check("rw_same_Y", {32'd0, Y}, 64'd7);

    // Clear mid-sequence overrides all load enables
    load_mdr(32'hDEADBEEF); MDRout = 1; Yin = 1; tick();
    load_mdr(32'h3);
    MDRout = 1; alu[12] = 1; Zin = 1; rin = '1;
    {HIin, LOin, PCin, IRin, Yin, MARin} = '1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_all_zero("clear_mid");

    for (int i = 0; i < 200; i++) begin
      int          op;
      logic [31:0] y, b;
      op = int'($urandom_range(13));
      y = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(40)) : $urandom;
      if (y == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'h1;
      alu_op(op, y, b);
      check($sformatf("rand%0d_op%0d", i, op), Z, ref_alu(op, y, b));
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on the rising edge.
REQ-002 SHALL have port clear, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have ports R0in..R15in, HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin, input, 1 each, register load enables.
REQ-004 SHALL have ports R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout, input, 1 each, bus source selects.
REQ-005 SHALL have ports IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV, input, 1 each, ALU operation selects.
REQ-006 SHALL have ports Read (input, 1, MDR source is memory) and Mdatain (input, 32, memory read data).
REQ-007 SHALL have ports R0..R15, HI, LO, PC_out, IR, MAR, Y, output, 32 each, register contents.
REQ-008 SHALL have port Z, output, 64, ALU result register.
REQ-009 SHALL have port BusMuxOut_signal, output, 32, current bus value.

Function
REQ-010 Bus: combinational mux driven by the asserted *out select; no select asserted -> 0.
REQ-011 Multiple selects asserted: lowest-listed wins, in order R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout.
REQ-012 Zhighout drives Z[63:32]; Zlowout drives Z[31:0]; InPortout drives 0; Cout drives IR[18:0] sign-extended to 32 bits.
REQ-013 Every 32-bit register (R0..R15, HI, LO, PC, IR, Y, MAR) loads the bus on the rising edge when its *in is high; otherwise holds. R0 is an ordinary register.
REQ-014 MDR loads on MDRin: Mdatain when Read=1, else bus.
REQ-015 ALU: A = Y, B = bus; combinational 64-bit result; Z loads it on the rising edge when Zin=1.
REQ-016 ADD/SUB/AND/OR: 32-bit Y op B, wrap-around, Z[63:32]=0.
REQ-017 SHR/SHRA/SHL/ROR/ROL: Y shifted/rotated by B[4:0]; SHRA sign-fills; Z[63:32]=0.
REQ-018 NEG: 0-B; NOT: ~B; IncPC: B+1; all with Z[63:32]=0.
REQ-019 MUL: signed 32x32 Y*B -> full 64-bit product in Z.
REQ-020 DIV: signed Y/B; Z[31:0]=quotient (truncated toward zero), Z[63:32]=remainder (sign of Y); B=0 -> Z=0.
REQ-021 Multiple ALU selects: priority IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV; none asserted -> result 0.
REQ-022 Register read and write in same cycle: readers see the old value; the new value is visible after the edge.
REQ-023 All outputs are direct register contents, no extra latency.

Reset
REQ-024 clear=1 at a rising edge SHALL zero R0..R15, HI, LO, PC, IR, Y, MAR, MDR and Z, overriding all load enables.
REQ-025 Clear asserted mid-sequence SHALL discard the operation in progress; state is all-zero the following cycle.

Configuration
REQ-026 Macro DATAPATH_DIV_EN: defined -> divider per REQ-020; undefined -> no divider logic, DIV yields result 0.

Verification
REQ-027 clear for one cycle -> all register outputs and Z equal 0 after the edge.
REQ-028 Load R1=0x05, R3=0x10 via Read/MDRin then MDRout/Rxin; R3out,Yin; R1out,MUL,Zin; Zlowout,LOin; Zhighout,HIin -> LO=0x00000050, HI=0x00000000.
REQ-029 PC=0: PCout,MARin,IncPC,Zin then Zlowout,PCin -> MAR=0, PC=1; Read,MDRin with Mdatain=0x112B0000 then MDRout,IRin -> IR=0x112B0000.
REQ-030 Y=0xFFFFFFFE, B=0x00000003, MUL -> Z=0xFFFFFFFF_FFFFFFFA; AND with Y=0x67, B=0x10 -> Z[31:0]=0x00000000.
REQ-031 DIV Y=17, B=5 -> Z[31:0]=3, Z[63:32]=2; DIV by 0 -> Z=0 (with DATAPATH_DIV_EN).
REQ-032 SHRA Y=0x80000000 by 4 -> 0xF8000000; ROL Y=0x80000001 by 1 -> 0x00000003.
